// File: rtl/gdiv_nch.sv
// gdiv_nch: multi-channel unary gradient divider.
// Each channel runs a saturating up/down counter. The counter climbs on
// dividend and falls on (counter >= random number) & divisor, so it settles
// where the comparison density equals dividend/divisor. A shared warm-up FSM
// masks the quotient until the counters have had time to settle.
// The FSM state is held in the enum signal `state` so checkers can bind to it.
module gdiv_nch #(
  parameter int CWIDTH = 4,
  parameter int NCH    = 2,
  parameter int INIT   = 2 ** (CWIDTH - 1),
  parameter int WARMUP = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic [NCH*CWIDTH-1:0]   rand_num,
  input  logic [NCH-1:0]          dividend,
  input  logic [NCH-1:0]          divisor,
  output logic [NCH-1:0]          quotient,
  output logic                    out_valid,
  output logic [NCH*CWIDTH-1:0]   cnt_out
);

  localparam int WW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
  localparam logic [CWIDTH-1:0] INIT_V = CWIDTH'(INIT);
  localparam logic [CWIDTH-1:0] CMAX   = '1;
  localparam logic [CWIDTH-1:0] CMIN   = '0;
  // Last warm-up count; unused when WARMUP is 0 because reset goes straight to RUN.
  localparam logic [WW-1:0] WLAST = WW'((WARMUP > 0) ? WARMUP - 1 : 0);

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam state_t RST_STATE = (WARMUP == 0) ? RUN : WARM;

  state_t                     state;
  state_t                     state_nxt;
  logic [WW-1:0]              wcnt;
  logic [WW-1:0]              wcnt_nxt;
  logic [NCH-1:0][CWIDTH-1:0] cnt;
  logic [NCH-1:0][CWIDTH-1:0] cnt_nxt;
  logic [NCH-1:0]             cmp;
  logic [NCH-1:0]             inc;
  logic [NCH-1:0]             dec;

  // Per-channel comparison and saturating step decision.
  always_comb begin
    cmp     = '0;
    inc     = '0;
    dec     = '0;
    cnt_nxt = cnt;
    for (int i = 0; i < NCH; i++) begin
      cmp[i] = (cnt[i] >= rand_num[i*CWIDTH +: CWIDTH]);
      inc[i] = dividend[i];
      dec[i] = cmp[i] & divisor[i];
      if (inc[i] && !dec[i] && (cnt[i] != CMAX)) begin
        cnt_nxt[i] = cnt[i] + CWIDTH'(1);
      end else if (!inc[i] && dec[i] && (cnt[i] != CMIN)) begin
        cnt_nxt[i] = cnt[i] - CWIDTH'(1);
      end
    end
  end

  // Counter register: reset/clear reload INIT, otherwise step only when enabled.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= INIT_V;
      end
    end else if (en) begin
      cnt <= cnt_nxt;
    end
  end

  // Warm-up FSM next state: count enabled cycles, release after WARMUP of them.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    if (en && (state == WARM)) begin
      if (wcnt == WLAST) begin
        state_nxt = RUN;
      end else begin
        wcnt_nxt = wcnt + WW'(1);
      end
    end
  end

  // Warm-up FSM state register; rst and clr both restart warm-up.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= RST_STATE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  assign out_valid = (state == RUN);
  assign quotient  = cmp & {NCH{out_valid}};
  assign cnt_out   = cnt;

endmodule

// File: tb/tb_gdiv_nch.sv
// tb_gdiv_nch: randomized scoreboard bench for gdiv_nch (CWIDTH=4, NCH=2,
// INIT=8, WARMUP=4). The driver computes each cycle's expected outputs from a
// plain arithmetic model and queues them; the monitor pops and compares.
module tb_gdiv_nch;

  localparam int CW   = 4;
  localparam int N    = 2;
  localparam int INIT = 8;
  localparam int WU   = 4;
  localparam int RW   = N * CW;
  localparam int EW   = 1 + N + RW;
  localparam int CMAXI = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          en;
  logic          clr;
  logic [RW-1:0] rand_num;
  logic [N-1:0]  dividend;
  logic [N-1:0]  divisor;
  logic [N-1:0]  quotient;
  logic          out_valid;
  logic [RW-1:0] cnt_out;

  gdiv_nch #(.CWIDTH(CW), .NCH(N), .INIT(INIT), .WARMUP(WU)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
    .rand_num (rand_num),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .out_valid(out_valid),
    .cnt_out  (cnt_out)
  );

  // Clock and initial input values.
  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    en       = 1'b0;
    clr      = 1'b0;
    rand_num = '0;
    dividend = '0;
    divisor  = '0;
    forever #5 clk = ~clk;
  end

  // Scoreboard entry: {conv_phase, known, out_valid, quotient, cnt_out}.
  logic [EW+1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int conv_n = 0;
  int ones0  = 0;
  int ones1  = 0;

  // Reference model: counter values, enabled edges since reset, validity.
  int   m_cnt[N];
  int   m_edges = 0;
  logic m_known = 1'b0;

  function automatic logic bern(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  task automatic step(input logic r, input logic c, input logic e,
                      input logic [RW-1:0] rn, input logic [N-1:0] dv,
                      input logic [N-1:0] ds, input logic conv);
    logic          ov;
    logic [N-1:0]  q;
    logic [RW-1:0] cv;
    int            rv;
    @(negedge clk);
    rst = r; clr = c; en = e; rand_num = rn; dividend = dv; divisor = ds;
    ov = (m_edges >= WU);
    q  = '0;
    cv = '0;
    for (int i = 0; i < N; i++) begin
      rv = int'(rn[i*CW +: CW]);
      q[i] = (m_cnt[i] >= rv) && ov;
      cv[i*CW +: CW] = CW'(m_cnt[i]);
    end
    exp_q.push_back({conv, m_known, ov, q, cv});
    // Effect of the coming rising edge.
    if (r || c) begin
      for (int i = 0; i < N; i++) m_cnt[i] = INIT;
      m_edges = 0;
      m_known = 1'b1;
    end else if (e) begin
      for (int i = 0; i < N; i++) begin
        rv = int'(rn[i*CW +: CW]);
        if (dv[i] && !(ds[i] && m_cnt[i] >= rv)) m_cnt[i] = (m_cnt[i] < CMAXI) ? m_cnt[i] + 1 : CMAXI;
        else if (!dv[i] && ds[i] && m_cnt[i] >= rv) m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end
      if (m_edges < WU) m_edges++;
    end
  endtask

  // Monitor: one expected entry per cycle, compared away from the clock edge.
  initial begin
    logic [EW+1:0] e;
    logic [EW-1:0] got;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[EW]) begin
          n_cmp++;
          got = {out_valid, quotient, cnt_out};
          if (got !== e[EW-1:0]) begin
            n_fail++;
            $display("FAIL cycle_check t=%0t: got ov=%b q=%b cnt=%h, expected ov=%b q=%b cnt=%h",
                     $time, out_valid, quotient, cnt_out, e[EW-1], e[EW-2 -: N], e[RW-1:0]);
          end
        end
        if (e[EW+1]) begin
          conv_n++;
          ones0 += int'(quotient[0]);
          ones1 += int'(quotient[1]);
        end
      end
    end
  end

  // Stimulus sequence followed by final checks and summary.
  initial begin
    int   en_pat[6];
    real  mean0;
    real  mean1;
    en_pat = '{1, 0, 1, 1, 0, 1};
    for (int i = 0; i < N; i++) m_cnt[i] = INIT;

    // Reset for two cycles, then idle.
    repeat (2) step(1'b1, 1'b0, 1'b0, RW'($urandom()), 2'b00, 2'b00, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, RW'($urandom()), 2'b11, 2'b00, 1'b0);

    // Warm-up with gaps in en.
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b0, en_pat[i] != 0, RW'($urandom()), N'($urandom()), N'($urandom()), 1'b0);

    // Saturate high, then drain to zero with rand_num=0.
    repeat (20) step(1'b0, 1'b0, 1'b1, RW'($urandom()), 2'b11, 2'b00, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b1, '0, 2'b00, 2'b11, 1'b0);

    // Hold: inc and dec together, then en=0 freeze.
    repeat (10) step(1'b0, 1'b0, 1'b1, '0, 2'b11, 2'b11, 1'b0);
    repeat (5)  step(1'b0, 1'b0, 1'b0, RW'($urandom()), 2'b11, 2'b00, 1'b0);

    // Clear in RUN with en=0.
    step(1'b0, 1'b1, 1'b0, RW'($urandom()), 2'b11, 2'b00, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, RW'($urandom()), 2'b11, 2'b00, 1'b0);

    // Clear on the final warm-up edge keeps the block warming up.
    repeat (3) step(1'b0, 1'b0, 1'b1, RW'($urandom()), N'($urandom()), N'($urandom()), 1'b0);
    step(1'b0, 1'b1, 1'b1, RW'($urandom()), N'($urandom()), N'($urandom()), 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b1, RW'($urandom()), N'($urandom()), N'($urandom()), 1'b0);

    // Random mix of en, clr and rst.
    repeat (400)
      step(bern(1), bern(3), bern(80), RW'($urandom()), N'($urandom()), N'($urandom()), 1'b0);

    // Convergence: quotient density should approach dividend/divisor = 0.5.
    step(1'b0, 1'b1, 1'b0, '0, 2'b00, 2'b00, 1'b0);
    repeat (WU + 64)
      step(1'b0, 1'b0, 1'b1, RW'($urandom()), {bern(30), bern(25)}, {bern(60), bern(50)}, 1'b0);
    repeat (4096)
      step(1'b0, 1'b0, 1'b1, RW'($urandom()), {bern(30), bern(25)}, {bern(60), bern(50)}, 1'b1);

    repeat (3) @(negedge clk);
    #5;

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end

    mean0 = (conv_n > 0) ? real'(ones0) / real'(conv_n) : 0.0;
    mean1 = (conv_n > 0) ? real'(ones1) / real'(conv_n) : 0.0;
    n_cmp++;
    if (conv_n != 4096 || mean0 < 0.45 || mean0 > 0.55) begin
      n_fail++;
      $display("FAIL conv_ch0: mean %f over %0d cycles, expected 0.50 +/- 0.05 over 4096", mean0, conv_n);
    end
    n_cmp++;
    if (conv_n != 4096 || mean1 < 0.45 || mean1 > 0.55) begin
      n_fail++;
      $display("FAIL conv_ch1: mean %f over %0d cycles, expected 0.50 +/- 0.05 over 4096", mean1, conv_n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gdiv_nch.md
# gdiv_nch

Parametrised, multi-channel successor of the 4-bit unary gradient divider. Each of NCH independent channels divides a unipolar dividend bitstream by a divisor bitstream. Each channel uses a saturating up/down counter compared against a per-channel random number. The block adds:
- configurable counter width and initial value;
- a clock enable and a synchronous clear;
- a warm-up phase that masks the quotient until the counters have had time to converge.

It sits in the scu/gdiv datapath, fed by RNG/SNG blocks and driving downstream unary arithmetic.

## Interface
Parameters:
- CWIDTH, 4, counter and random-number width per channel (≥2)
- NCH, 2, number of independent divider channels (≥1)
- INIT, 2**(CWIDTH-1), counter value after reset/clear (0 ≤ INIT ≤ 2**CWIDTH-1)
- WARMUP, 16, enabled cycles before quotient is released (0 allowed)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  advance counters and warm-up counter when 1
- clr  in  1  synchronous re-initialisation, identical effect to rst
- rand_num  in  NCH*CWIDTH  per-channel random number; channel i at [i*CWIDTH +: CWIDTH]
- dividend  in  NCH  dividend bit per channel
- divisor  in  NCH  divisor bit per channel
- quotient  out  NCH  quotient bit per channel, masked to 0 while out_valid=0
- out_valid  out  1  1 once warm-up is complete
- cnt_out  out  NCH*CWIDTH  per-channel counter value, for debug/observation

## Operation
- Per channel i, the raw comparison is `cmp[i] = (cnt[i] >= rand_num[i])`, unsigned, combinational.
- Per channel i, the step controls are:
  - `inc[i] = dividend[i]`
  - `dec[i] = cmp[i] & divisor[i]`
- Raw cmp drives dec in every state, including warm-up, so counters converge during warm-up.
- Counter update when en=1:
  - inc & ~dec & cnt ≠ 2**CWIDTH-1 → cnt+1
  - ~inc & dec & cnt ≠ 0 → cnt-1
  - otherwise hold: inc&dec both high, neither high, or saturated
  - No wrap-around, ever.
- Output masking:
  - `quotient[i] = cmp[i] & out_valid`
  - `cnt_out` = cnt, unmasked.
- FSM, 2 states: WARM and RUN.
  - Warm-up counter wcnt has width max(1, $clog2(WARMUP+1)).
  - WARM:
    - out_valid=0.
    - When en=1: if wcnt == WARMUP-1, go to RUN; else wcnt+1.
    - When en=0: hold.
  - RUN:
    - out_valid=1.
    - Stays in RUN until rst or clr.
  - If WARMUP=0, rst/clr enter RUN directly and out_valid=1 from the first cycle after reset.
- Priority: rst > clr > en.
  - rst or clr: all cnt=INIT, wcnt=0, state=WARM (RUN if WARMUP=0).
  - clr ignores en.
- en=0 freezes all counters, wcnt and state. quotient still follows rand_num combinationally (masked).
- Channels are fully independent; there is no shared state except en/clr/FSM.

## Timing
- Reset values at the first edge with rst=1:
  - cnt_out = INIT on every channel
  - out_valid = 0 (1 if WARMUP=0)
  - quotient = 0 (if WARMUP>0)
- Counter latency: the inc/dec decision at edge k is visible on cnt_out and on cmp after edge k. It is a 1-cycle feedback loop, with no extra pipeline.
- quotient is combinational from cnt, rand_num and out_valid. Zero-latency from rand_num.
- out_valid rises after exactly WARMUP rising edges with en=1 following reset/clr. Disabled cycles are not counted.
- clr asserted mid-RUN: out_valid=0 and cnt=INIT after that edge, and quotient is 0 in the next cycle.
- rst or clr in the same cycle as the last warm-up edge: reset wins, and the FSM stays in WARM.

## Test plan
- Reset (CWIDTH=4, NCH=2, INIT=8, WARMUP=4): assert rst 2 cycles, then release → cnt_out = {8,8}, out_valid=0, quotient=00.
- Warm-up with gaps: en pattern 1,0,1,1,0,1 → out_valid rises after the 6th edge (4th enabled edge). quotient=00 before that, then equals cmp.
- Saturation:
  - dividend=11, divisor=00 for 20 cycles → cnt 15 and held (no wrap to 0).
  - Then dividend=00, divisor=11, rand_num=0 → cnt decreases to 0 and holds, with quotient=11 throughout.
- Hold cases:
  - dividend=1, divisor=1, cmp=1 for 10 cycles → cnt unchanged.
  - en=0 with dividend=1 → cnt and wcnt frozen.
  - clr=1 with en=0 in RUN → cnt={8,8}, out_valid=0 next cycle.
- Convergence: ch0 dividend p=0.25, divisor p=0.5; ch1 dividend p=0.3, divisor p=0.6; rand_num uniform 0..15 from independent LFSRs, 4096 cycles after warm-up → quotient mean 0.50 ± 0.05 on each channel.
- Channel independence (NCH=4, CWIDTH=6): drive ch2 with dividend=1, others with 0 → only cnt_out ch2 rises (to 63 saturating). The others decrease or hold per their divisor inputs.
